// File: rtl/ivs_dma_pkg.sv
// ---------------------------------------------------------------------------
// ivs_dma_pkg
// Shared definitions for the IVS DMA write split interface.
//   - Data path width, strobe width and sub-burst limits
//   - FSM state encoding
//   - Small arithmetic helpers for the sub-burst planner
// ---------------------------------------------------------------------------
package ivs_dma_pkg;

  localparam int DW        = 64;
  localparam int SW        = DW / 8;
  localparam int BURST_MAX = 16;
  localparam int BOUNDARY  = 128;
  localparam int LEN_W     = $clog2(BURST_MAX);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_CAL  = 3'd1,
    ST_CMD_REQ  = 3'd2,
    ST_DATA_PRO = 3'd3,
    ST_POS_CAL  = 3'd4
  } state_e;

  // Bytes the next sub-burst may carry: whatever is left, capped by the
  // distance to the next 128-byte boundary (1..128).
  function automatic logic [7:0] calc_chunk(input logic [8:0] left,
                                            input logic [6:0] base_lo);
    logic [8:0] room;
    room = 9'(BOUNDARY) - {2'b00, base_lo};
    return (left < room) ? left[7:0] : room[7:0];
  endfunction

  // Beats minus one for a chunk starting at byte lane 'lane'. A chunk never
  // crosses a 128-byte boundary, so the result always fits in LEN_W bits.
  function automatic logic [LEN_W-1:0] calc_len(input logic [2:0] lane,
                                                input logic [7:0] chunk);
    logic [8:0] span;
    span = {6'd0, lane} + {1'b0, chunk} - 9'd1;
    return LEN_W'(span >> 3);
  endfunction

  // Upstream words needed to carry 'bytes' lane-0-packed bytes.
  function automatic logic [5:0] calc_words(input logic [8:0] bytes);
    return 6'((10'(bytes) + 10'd7) >> 3);
  endfunction

endpackage

// File: rtl/ivs_dma_wr_align.sv
// ---------------------------------------------------------------------------
// ivs_dma_wr_align
// Realigns the lane-0-packed upstream stream onto the (possibly unaligned)
// destination address and generates byte strobes.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : clear the carry register (new transfer accepted)
//   pop_i          : an upstream word is consumed this cycle
//   use_word_i     : the current beat takes a fresh upstream word
//   en_i           : data phase active; outputs are zero otherwise
//   first_i/last_i : current beat is the first / final beat of the transfer
//   ofst_i         : start lane of the transfer
//   end_lane_i     : lane of the last byte of the transfer
//   word_i         : upstream data word
//   data_o/strb_o  : realigned write data and byte strobes
// ---------------------------------------------------------------------------
module ivs_dma_wr_align
  import ivs_dma_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          pop_i,
  input  logic          use_word_i,
  input  logic          en_i,
  input  logic          first_i,
  input  logic          last_i,
  input  logic [2:0]    ofst_i,
  input  logic [2:0]    end_lane_i,
  input  logic [DW-1:0] word_i,
  output logic [DW-1:0] data_o,
  output logic [SW-1:0] strb_o
);

  localparam int SH_W = $clog2(DW) + 1;

  logic [DW-1:0]   carry_q, carry_d;
  logic [SH_W-1:0] lo_sh, hi_sh;
  logic [DW-1:0]   cur_word, carry_part;
  logic [SW-1:0]   strb;

  // The previous upstream word supplies the low lanes of every beat; it is
  // kept across sub-bursts because boundaries fall on word edges.
  always_comb begin
    carry_d = carry_q;
    if (clr_i) begin
      carry_d = '0;
    end else if (pop_i) begin
      carry_d = word_i;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst_i) begin
      carry_q <= '0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign lo_sh = {1'b0, ofst_i, 3'b000};
  assign hi_sh = SH_W'(DW) - lo_sh;

  always_comb begin
    // NOTE: every variable is given a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    cur_word   = use_word_i ? word_i : '0;
    // A shift by the full width is avoided: lane 0 start needs no carry.
    carry_part = (ofst_i == 3'd0) ? '0 : (carry_q >> hi_sh);

    strb = '1;
    if (first_i) begin
      strb = strb & ({SW{1'b1}} << ofst_i);
    end
    if (last_i) begin
      strb = strb & ({SW{1'b1}} >> (3'd7 - end_lane_i));
    end

    data_o = en_i ? ((cur_word << lo_sh) | carry_part) : '0;
    strb_o = en_i ? strb : '0;
  end

endmodule

// File: rtl/ivs_dma_wr_split_inf.sv
// ---------------------------------------------------------------------------
// ivs_dma_wr_split_inf
// Splits one byte-granular write request into bus sub-bursts of at most 16
// beats that never cross a 128-byte boundary, realigning the upstream data.
//   clk_i, rst_i, sw_rst_i      : clock, sync reset, soft-reset pulse
//   ori_req/base/bytes/ack/done : upstream request (bytes 0 means 256)
//   ori_wdata/wvalid/wrdy       : upstream lane-0-packed data stream
//   split_req/base/len/ack      : sub-burst command (len = beats - 1)
//   split_wdata/wstrb/wvalid/wlast/wrdy : downstream write data
// ---------------------------------------------------------------------------
module ivs_dma_wr_split_inf
  import ivs_dma_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_rst_i,
  input  logic             ori_req_i,
  input  logic [31:0]      ori_base_i,
  input  logic [7:0]       ori_bytes_i,
  output logic             ori_ack_o,
  output logic             ori_done_o,
  input  logic [DW-1:0]    ori_wdata_i,
  input  logic             ori_wvalid_i,
  output logic             ori_wrdy_o,
  output logic             split_req_o,
  output logic [31:0]      split_base_o,
  output logic [LEN_W-1:0] split_len_o,
  input  logic             split_ack_i,
  output logic [DW-1:0]    split_wdata_o,
  output logic [SW-1:0]    split_wstrb_o,
  output logic             split_wvalid_o,
  output logic             split_wlast_o,
  input  logic             split_wrdy_i
);

  state_e           state_q, state_d;
  logic [31:0]      cur_base_q, cur_base_d;
  logic [8:0]       left_q, left_d;
  logic [2:0]       ofst_q, ofst_d;
  logic [2:0]       end_lane_q, end_lane_d;
  logic [7:0]       chunk_q, chunk_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [5:0]       words_q, words_d;
  logic [5:0]       popped_q, popped_d;
  logic             last_burst_q, last_burst_d;
  logic             first_q, first_d;
  logic             sw_rst_pro_q, sw_rst_pro_d;

  logic abort, accept, in_data, need_pop, last_beat, beat_hs, pop;

  // A soft reset seen this cycle already blocks new work.
  assign abort     = sw_rst_i | sw_rst_pro_q;
  assign accept    = (state_q == ST_IDLE) & ori_req_i & ~abort;
  assign in_data   = (state_q == ST_DATA_PRO);
  // Once all upstream words are in, remaining beats drain the carry only.
  assign need_pop  = (popped_q < words_q);
  assign last_beat = (beat_cnt_q == len_q);
  assign beat_hs   = split_wvalid_o & split_wrdy_i;
  assign pop       = ori_wvalid_i & ori_wrdy_o;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_PRE_CAL;
      ST_PRE_CAL:  state_d = ST_CMD_REQ;
      ST_CMD_REQ:  if (split_ack_i) state_d = ST_DATA_PRO;
      ST_DATA_PRO: if (beat_hs && last_beat) state_d = ST_POS_CAL;
      ST_POS_CAL:  state_d = (~last_burst_q & ~abort) ? ST_PRE_CAL : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ori_ack_o      = 1'b0;
    ori_done_o     = 1'b0;
    ori_wrdy_o     = 1'b0;
    split_req_o    = 1'b0;
    split_base_o   = '0;
    split_len_o    = '0;
    split_wvalid_o = 1'b0;
    split_wlast_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: ori_ack_o = accept;
      ST_CMD_REQ: begin
        split_req_o  = 1'b1;
        split_base_o = cur_base_q;
        split_len_o  = len_q;
      end
      ST_DATA_PRO: begin
        split_wvalid_o = need_pop ? ori_wvalid_i : 1'b1;
        ori_wrdy_o     = need_pop & split_wrdy_i;
        split_wlast_o  = last_beat;
        ori_done_o     = split_wvalid_o & split_wrdy_i & last_beat &
                         last_burst_q & ~abort;
      end
      default: ;
    endcase
  end

  // ---------------- Transfer bookkeeping ----------------
  always_comb begin
    cur_base_d   = cur_base_q;
    left_d       = left_q;
    ofst_d       = ofst_q;
    end_lane_d   = end_lane_q;
    chunk_d      = chunk_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    words_d      = words_q;
    popped_d     = popped_q;
    last_burst_d = last_burst_q;
    first_d      = first_q;
    // Held while a command is outstanding so that it finishes its beats.
    sw_rst_pro_d = sw_rst_i |
                   (sw_rst_pro_q & ((state_q == ST_CMD_REQ) | in_data));

    if (accept) begin
      cur_base_d   = ori_base_i;
      left_d       = {ori_bytes_i == 8'd0, ori_bytes_i};
      ofst_d       = ori_base_i[2:0];
      // Modulo-8 arithmetic also covers the 256-byte case (bytes = 0).
      end_lane_d   = ori_base_i[2:0] + ori_bytes_i[2:0] - 3'd1;
      words_d      = calc_words({ori_bytes_i == 8'd0, ori_bytes_i});
      popped_d     = '0;
      first_d      = 1'b1;
      last_burst_d = 1'b0;
    end

    if (state_q == ST_PRE_CAL) begin
      chunk_d = calc_chunk(left_q, cur_base_q[6:0]);
      len_d   = calc_len(cur_base_q[2:0], chunk_d);
    end

    if ((state_q == ST_CMD_REQ) && split_ack_i) begin
      cur_base_d   = cur_base_q + {24'd0, chunk_q};
      left_d       = left_q - {1'b0, chunk_q};
      last_burst_d = (left_q == {1'b0, chunk_q});
      beat_cnt_d   = '0;
    end

    if (beat_hs) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      first_d    = 1'b0;
    end
    if (pop) begin
      popped_d = popped_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_base_q   <= '0;
      left_q       <= '0;
      ofst_q       <= '0;
      end_lane_q   <= '0;
      chunk_q      <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      words_q      <= '0;
      popped_q     <= '0;
      last_burst_q <= 1'b0;
      first_q      <= 1'b0;
      sw_rst_pro_q <= 1'b0;
    end else begin
      cur_base_q   <= cur_base_d;
      left_q       <= left_d;
      ofst_q       <= ofst_d;
      end_lane_q   <= end_lane_d;
      chunk_q      <= chunk_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      words_q      <= words_d;
      popped_q     <= popped_d;
      last_burst_q <= last_burst_d;
      first_q      <= first_d;
      sw_rst_pro_q <= sw_rst_pro_d;
    end
  end

  // ---------------- Data realignment ----------------
  ivs_dma_wr_align u_align (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .pop_i      (pop),
    .use_word_i (need_pop),
    .en_i       (in_data),
    .first_i    (first_q),
    .last_i     (last_beat & last_burst_q),
    .ofst_i     (ofst_q),
    .end_lane_i (end_lane_q),
    .word_i     (ori_wdata_i),
    .data_o     (split_wdata_o),
    .strb_o     (split_wstrb_o)
  );

endmodule

// File: doc/ivs_dma_wr_split_inf.md
# ivs_dma_wr_split_inf

Write-direction counterpart of the DMA read split interface. It takes one byte-granular write request (base, byte count) plus a lane-0-packed 64-bit data stream from the IVS engine. It issues bus write sub-bursts of at most 16 beats that never cross a 128-byte boundary, and therefore never a 4 KB boundary. Along the way it realigns data and generates byte strobes for an unaligned base.

## Interface
- DW, 64: data width; fixed, strobe width DW/8 = 8.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sw_rst  in  1  soft reset request, one-cycle pulse.
- ori_req  in  1  write request, level, held until ori_ack.
- ori_base  in  32  byte start address.
- ori_bytes  in  8  byte count; 0 means 256.
- ori_ack  out  1  one-cycle request-accept pulse.
- ori_done  out  1  one-cycle pulse on the final downstream beat handshake.
- ori_wdata  in  64  upstream data; byte n of the transfer sits at word n/8, lane n%8.
- ori_wvalid  in  1  upstream valid.
- ori_wrdy  out  1  upstream ready.
- split_req  out  1  sub-burst command valid.
- split_base  out  32  sub-burst byte start address (unaligned allowed).
- split_len  out  4  beats minus 1.
- split_ack  in  1  command accept.
- split_wdata  out  64  aligned write data.
- split_wstrb  out  8  byte strobes.
- split_wvalid  out  1  data valid.
- split_wlast  out  1  last beat of the sub-burst.
- split_wrdy  in  1  downstream data ready.

## Operation
- **FSM states:** IDLE, PRE_CAL, CMD_REQ, DATA_PRO, POS_CAL.
  - IDLE→PRE_CAL on ori_req & ~sw_rst_pro. In that cycle: ori_ack=1; latch cur_base=ori_base, left={ori_bytes==0,ori_bytes} (9 bits), ofst=ori_base[2:0]; clear the carry register and the popped-word counter.
  - PRE_CAL→CMD_REQ, always. Registers chunk = min(left, 128−cur_base[6:0]) (≤128) and len = (cur_base[2:0]+chunk−1)>>3.
  - CMD_REQ holds split_req=1 with split_base=cur_base and split_len=len. On split_ack: →DATA_PRO, cur_base+=chunk, left−=chunk, last_burst=(left==chunk).
  - DATA_PRO→POS_CAL on the split_wlast handshake.
  - POS_CAL→PRE_CAL if ~last_burst & ~sw_rst_pro; otherwise →IDLE.
- **Word counts:** upstream words W=ceil(bytes/8); downstream beats D=ceil((ofst+bytes)/8), so D∈{W,W+1}.
- **Pop rule:** a beat pops upstream while popped<W (need_pop). Otherwise it is a carry-only beat.
  - split_wvalid = DATA_PRO & (need_pop ? ori_wvalid : 1).
  - ori_wrdy = DATA_PRO & need_pop & split_wrdy.
- **Realign:**
  - split_wdata = (cur_word<<8·ofst) | (carry>>8·(8−ofst)); ofst=0 passes data through.
  - carry ← ori_wdata on each pop; carry persists across sub-bursts of one transfer.
- **Strobes:** all ones except:
  - the first beat of the transfer, which is masked to lanes ≥ofst;
  - the final beat of the transfer, which is masked to lanes ≤ end_addr[2:0].
  - Interior sub-burst boundaries are 128-byte aligned, so they need no masking.
- **Soft reset:**
  - sw_rst sets sw_rst_pro; it clears when the FSM is neither in CMD_REQ nor in DATA_PRO.
  - An issued command always completes all its beats.
  - No further sub-burst is issued; return to IDLE with ori_done=0.
  - The upstream source is flushed by the same sw_rst.

## Timing
- **Reset values:** all outputs 0; FSM=IDLE; all counters and registers 0.
- **Request to command:** ori_req seen in IDLE → split_req asserted two cycles later (via PRE_CAL).
- **Data path:** zero bubble; split_wvalid/ori_wrdy are combinational pass-through, one beat per cycle at full rate.
- **Gap between sub-bursts:** POS_CAL + PRE_CAL, minimum 2 idle cycles before the next split_req.
- **split_req** is stable from assertion until split_ack.
- **Data phase:** no data beat is presented before split_ack. The beat counter is compared to the registered len for split_wlast.
- **ori_done** coincides with the final wlast handshake.
- **rst mid-transfer:** abandons everything immediately.

## Structure
- Shared package ivs_dma_pkg: FSM state encoding, DW, BURST_MAX=16, BOUNDARY=128.
- One sub-module, ivs_dma_wr_align: carry register, shifter and strobe generator, driven by pop/beat/first/last controls.

## Test plan
- **Aligned 128 B:** base 0x1000, bytes 128 → one burst, len 15, all strobes 0xFF, data unchanged, ori_done on beat 16.
- **Unaligned 16 B:** base 0x1003, bytes 16 → one burst, len 2; strobes 0xF8, 0xFF, 0x07; beat0 = word0<<24; beat2 is carry-only (2 pops, 3 beats).
- **4 KB crossing:** base 0x0FF8, bytes 32 → burst base 0x0FF8 len 0, then base 0x1000 len 2; 4 pops in total.
- **256-byte transfer:** base 0x2000, bytes 0 (=256) → bursts 0x2000 len 15 and 0x2080 len 15.
- **Backpressure:** base 0x3005, bytes 200, random split_wrdy/ori_wvalid gaps → scoreboard matches every byte address and strobe; no loss or duplication.
- **Soft reset:** sw_rst during DATA_PRO of burst 1 of 2 → burst 1 finishes with wlast, no second split_req, no ori_done, IDLE; ori_req is ignored until sw_rst_pro clears.
